// File: rtl/rob.sv
// Reorder buffer: a 2^ROB_W-entry circular buffer with 3-wide dispatch,
// 3-lane completion and 3-wide in-order retirement.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   rob_in[3]             dispatch request per slot (slot 0 oldest)
//   complete_valid[3]     completion strobe per lane
//   complete_entry[3]     ROB index completed on each lane
//   precise_state_valid   completing entry is a mispredicted branch
//   target_pc[3]          redirect PC per lane
//   BPRecoverEN           flush: empty the buffer
//   sq_stall[3]           store queue blocks retire slot i
//   dispatch_index[3]     entry allocated to each dispatch slot
//   struct_stall[3]       slot i has no free entry
//   retire_entry[3]       entry head+i retires this cycle
//
// Optional feature (macro ROB_RETIRE_PC_EN): adds retire_precise[3] and
// retire_target_pc[3], and keeps a target PC per entry.
module rob #(
  parameter int ROB_W = 5,
  parameter int XLEN  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [2:0]                 rob_in,
  input  logic [2:0]                 complete_valid,
  input  logic [2:0][ROB_W-1:0]      complete_entry,
  input  logic [2:0]                 precise_state_valid,
  input  logic [2:0][XLEN-1:0]       target_pc,
  input  logic                       BPRecoverEN,
  input  logic [2:0]                 sq_stall,
  output logic [2:0][ROB_W-1:0]      dispatch_index,
  output logic [2:0]                 struct_stall,
`ifdef ROB_RETIRE_PC_EN
  output logic [2:0]                 retire_precise,
  output logic [2:0][XLEN-1:0]       retire_target_pc,
`endif
  output logic [2:0]                 retire_entry
);
  localparam int DEPTH = 1 << ROB_W;
  localparam int CW    = ROB_W + 1;

  logic [ROB_W-1:0]            r_head, r_tail;
  logic [CW-1:0]               r_cnt;
  logic [DEPTH-1:0]            r_vld, r_cmp, r_prc;
`ifdef ROB_RETIRE_PC_EN
  logic [DEPTH-1:0][XLEN-1:0]  r_tpc;
`else
  logic                        w_unused_tpc;
  assign w_unused_tpc = ^target_pc;
`endif

  logic [CW-1:0]               w_free;
  logic [1:0]                  w_acc, w_incl, w_nalloc, w_nret;
  logic [2:0]                  w_alloc;
  logic [2:0][ROB_W-1:0]       w_ridx;
  logic                        w_go;

  // Free space ignores same-cycle retirement so the stall path does not
  // depend on the retire chain.
  assign w_free = CW'(DEPTH) - r_cnt;

  // Dispatch: slot i gets tail + (requests below i). Stalls fill in from
  // the youngest slot, so granted slots always take consecutive entries.
  always_comb begin
    w_acc          = '0;
    w_incl         = '0;
    w_nalloc       = '0;
    w_alloc        = '0;
    struct_stall   = '0;
    dispatch_index = '0;
    for (int i = 0; i < 3; i++) begin
      dispatch_index[i] = r_tail + ROB_W'(w_acc);
      w_incl            = w_acc + {1'b0, rob_in[i]};
      struct_stall[i]   = rob_in[i] && (CW'(w_incl) > w_free);
      w_alloc[i]        = rob_in[i] && !struct_stall[i];
      if (w_alloc[i]) w_nalloc = w_nalloc + 2'd1;
      w_acc = w_incl;
    end
  end

  // Retire chain: w_go carries "every lower slot retires and none of them
  // is a mispredicted branch" up to the next slot.
  always_comb begin
    w_go         = 1'b1;
    w_nret       = '0;
    w_ridx       = '0;
    retire_entry = '0;
    for (int i = 0; i < 3; i++) begin
      w_ridx[i]       = r_head + ROB_W'(i);
      retire_entry[i] = w_go && (r_cnt > CW'(i)) && r_cmp[w_ridx[i]] && !sq_stall[i];
      if (retire_entry[i]) w_nret = w_nret + 2'd1;
      w_go = retire_entry[i] && !r_prc[w_ridx[i]];
    end
  end

`ifdef ROB_RETIRE_PC_EN
  always_comb begin
    retire_precise   = '0;
    retire_target_pc = '0;
    for (int i = 0; i < 3; i++) begin
      retire_precise[i]   = r_prc[w_ridx[i]];
      retire_target_pc[i] = r_tpc[w_ridx[i]];
    end
  end

  // Only meaningful while the entry is valid, so no reset needed.
  always_ff @(posedge clock) begin
    if (!reset && !BPRecoverEN) begin
      for (int i = 0; i < 3; i++)
        if (complete_valid[i] && r_vld[complete_entry[i]])
          r_tpc[complete_entry[i]] <= target_pc[i];
    end
  end
`endif

  // Update order inside the edge: completion, then retirement, then
  // allocation, so allocation wins over a same-cycle completion.
  always_ff @(posedge clock) begin
    if (reset || BPRecoverEN) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
      r_cmp  <= '0;
      r_prc  <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (complete_valid[i] && r_vld[complete_entry[i]]) begin
          r_cmp[complete_entry[i]] <= 1'b1;
          r_prc[complete_entry[i]] <= precise_state_valid[i];
        end
      for (int i = 0; i < 3; i++)
        if (retire_entry[i]) begin
          r_vld[w_ridx[i]] <= 1'b0;
          r_cmp[w_ridx[i]] <= 1'b0;
          r_prc[w_ridx[i]] <= 1'b0;
        end
      for (int i = 0; i < 3; i++)
        if (w_alloc[i]) begin
          r_vld[dispatch_index[i]] <= 1'b1;
          r_cmp[dispatch_index[i]] <= 1'b0;
          r_prc[dispatch_index[i]] <= 1'b0;
        end
      r_head <= r_head + ROB_W'(w_nret);
      r_tail <= r_tail + ROB_W'(w_nalloc);
      r_cnt  <= r_cnt + CW'(w_nalloc) - CW'(w_nret);
    end
  end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: dispatch indexing, completion/retire rules,
// sq_stall and precise gating, full-buffer stalls, flush and reset.
module tb_rob;
  localparam int ROB_W = 5;
  localparam int XLEN  = 32;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [2:0]            rob_in, complete_valid, precise_state_valid, sq_stall;
  logic [2:0][ROB_W-1:0] complete_entry;
  logic [2:0][XLEN-1:0]  target_pc;
  logic                  BPRecoverEN;
  logic [2:0][ROB_W-1:0] dispatch_index;
  logic [2:0]            struct_stall, retire_entry;
`ifdef ROB_RETIRE_PC_EN
  logic [2:0]            retire_precise;
  logic [2:0][XLEN-1:0]  retire_target_pc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rob #(.ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .rob_in(rob_in),
    .complete_valid(complete_valid), .complete_entry(complete_entry),
    .precise_state_valid(precise_state_valid), .target_pc(target_pc),
    .BPRecoverEN(BPRecoverEN), .sq_stall(sq_stall),
    .dispatch_index(dispatch_index), .struct_stall(struct_stall),
`ifdef ROB_RETIRE_PC_EN
    .retire_precise(retire_precise), .retire_target_pc(retire_target_pc),
`endif
    .retire_entry(retire_entry)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rob_in = '0; complete_valid = '0; complete_entry = '0;
    precise_state_valid = '0; target_pc = '0; BPRecoverEN = 1'b0; sq_stall = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // n cycles of rob_in=pat, then idle
  task automatic disp(input logic [2:0] pat, input int n);
    for (int k = 0; k < n; k++) begin
      rob_in = pat;
      tick();
    end
    rob_in = '0;
  endtask

  task automatic comp(input logic [2:0] v, input logic [2:0][ROB_W-1:0] e,
                      input logic [2:0] p, input logic [31:0] pc0);
    complete_valid = v; complete_entry = e; precise_state_valid = p;
    target_pc = '0; target_pc[0] = pc0;
    tick();
    complete_valid = '0; precise_state_valid = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset state and first dispatch
    rob_in = 3'b111; #1;
    chk("rst_didx", 64'(dispatch_index), 64'({5'd2, 5'd1, 5'd0}));
    chk("rst_stall", 64'(struct_stall), 64'b000);
    chk("rst_ret", 64'(retire_entry), 64'b000);
    chk("rst_cnt", 64'(dut.r_cnt), 64'd0);
    tick(); #1;
    chk("didx_2nd", 64'(dispatch_index), 64'({5'd5, 5'd4, 5'd3}));
    rob_in = '0;

    // entries 0-2 live; complete only entry 1
    comp(3'b001, {5'd0, 5'd0, 5'd1}, 3'b000, 0); #1;
    chk("ret_no_head", 64'(retire_entry), 64'b000);
    // completion of entry 0 is not visible in its own cycle
    complete_valid = 3'b001; complete_entry = {5'd0, 5'd0, 5'd0}; #1;
    chk("ret_same_cyc", 64'(retire_entry), 64'b000);
    tick(); complete_valid = '0; #1;
    chk("ret_011", 64'(retire_entry), 64'b011);
    tick();
    chk("head_2", 64'(dut.r_head), 64'd2);
    chk("cnt_1", 64'(dut.r_cnt), 64'd1);

    // precise entry 0 blocks entry 1 behind it
    do_reset();
    disp(3'b111, 1);
    comp(3'b011, {5'd0, 5'd1, 5'd0}, 3'b001, 32'd5); #1;
    chk("ret_precise", 64'(retire_entry), 64'b001);
`ifdef ROB_RETIRE_PC_EN
    chk("ret_tpc", 64'(retire_target_pc[0]), 64'd5);
    chk("ret_prc", 64'(retire_precise), 64'b001);
`endif
    tick(); #1;
    chk("ret_after_prc", 64'(retire_entry), 64'b001);

    // sq_stall gating with 3 complete entries
    do_reset();
    disp(3'b111, 1);
    comp(3'b111, {5'd2, 5'd1, 5'd0}, 3'b000, 0);
    sq_stall = 3'b111; #1; chk("sq_111", 64'(retire_entry), 64'b000);
    sq_stall = 3'b010; #1; chk("sq_010", 64'(retire_entry), 64'b001);
    sq_stall = 3'b100; #1; chk("sq_100", 64'(retire_entry), 64'b011);
    sq_stall = 3'b000; #1; chk("sq_000", 64'(retire_entry), 64'b111);
    tick(); #1;
    chk("empty_ret", 64'(retire_entry), 64'b000);
    chk("empty_cnt", 64'(dut.r_cnt), 64'd0);

    // dispatch beats completion to the same entry (entry 3)
    rob_in = 3'b001; complete_valid = 3'b001; complete_entry = {5'd0, 5'd0, 5'd3};
    tick(); idle(); #1;
    chk("disp_prio", 64'(retire_entry), 64'b000);
    chk("disp_prio_cnt", 64'(dut.r_cnt), 64'd1);

    // near-full and full
    do_reset();
    disp(3'b111, 10);
    chk("cnt_30", 64'(dut.r_cnt), 64'd30);
    rob_in = 3'b111; #1;
    chk("stall_100", 64'(struct_stall), 64'b100);
    chk("didx_wrap", 64'(dispatch_index), 64'({5'd0, 5'd31, 5'd30}));
    tick();
    chk("cnt_32", 64'(dut.r_cnt), 64'd32);
    rob_in = 3'b001; #1; chk("full_001", 64'(struct_stall), 64'b001);
    rob_in = 3'b111; #1; chk("full_111", 64'(struct_stall), 64'b111);
    rob_in = '0;

    // flush with 10 live entries; retire still sees pre-flush state
    do_reset();
    disp(3'b111, 3);
    disp(3'b001, 1);
    comp(3'b001, {5'd0, 5'd0, 5'd0}, 3'b000, 0);
    chk("cnt_10", 64'(dut.r_cnt), 64'd10);
    BPRecoverEN = 1'b1; rob_in = 3'b111; complete_valid = 3'b001;
    complete_entry = {5'd0, 5'd0, 5'd1}; #1;
    chk("flush_ret_pre", 64'(retire_entry), 64'b001);
    tick(); idle(); rob_in = 3'b111; #1;
    chk("flush_cnt", 64'(dut.r_cnt), 64'd0);
    chk("flush_didx", 64'(dispatch_index), 64'({5'd2, 5'd1, 5'd0}));
    chk("flush_ret", 64'(retire_entry), 64'b000);
    rob_in = '0;

    // reset mid-operation wins over dispatch and flush
    disp(3'b111, 3);
    disp(3'b001, 1);
    comp(3'b001, {5'd0, 5'd0, 5'd0}, 3'b000, 0);
    reset = 1'b1; rob_in = 3'b111; BPRecoverEN = 1'b1;
    tick(); reset = 1'b0; idle(); rob_in = 3'b111; #1;
    chk("rst_mid_cnt", 64'(dut.r_cnt), 64'd0);
    chk("rst_mid_didx", 64'(dispatch_index), 64'({5'd2, 5'd1, 5'd0}));
    chk("rst_mid_ret", 64'(retire_entry), 64'b000);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
